// File: rtl/tetris_dp_param.sv
// Tetris playfield, active piece and control FSM; optional hard drop under TETRIS_HARD_DROP_EN.
// All outputs registered, one state step per clka edge; no backpressure, inputs outside FALL are dropped.
module tetris_dp_param #(
   parameter int COLS  = 4,
   parameter int ROWS  = 8,
   parameter int LOC_W = $clog2(COLS*ROWS)
) (
   input  logic                 clka,
   input  logic                 restart_n,
   input  logic                 tick,
   input  logic [1:0]           move,
   input  logic [1:0]           piece_in,
`ifdef TETRIS_HARD_DROP_EN
   input  logic                 hard_drop,
`endif
   output logic [COLS*ROWS-1:0] board_out,
   output logic [1:0]           curr_piece,
   output logic [1:0]           rotation,
   output logic [LOC_W-1:0]     location,
   output logic                 touched,
   output logic [15:0]          lines_cleared,
   output logic                 game_over,
   output logic [2:0]           state
);
   localparam int N         = COLS*ROWS;
   localparam int ROW_W     = $clog2(ROWS);
   localparam int COL_W     = $clog2(COLS);
   localparam int SPAWN_COL = (COLS-2)/2;

   typedef enum logic [2:0] {
      S_SPAWN = 3'd0,
      S_FALL  = 3'd1,
      S_LOCK  = 3'd2,
      S_CLEAR = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t           state_q;
   logic [N-1:0]     board_q;
   logic [1:0]       piece_q;
   logic [1:0]       rot_q;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic [LOC_W-1:0] loc_q;
   logic             touched_q;
   logic [15:0]      lines_q;
   logic             go_q;
   logic [ROW_W-1:0] scan_q;
   logic             pend_q;

   // Mask bit order is {b3,b2,b1,b0}; each clockwise step maps b0->b1->b3->b2->b0.
   function automatic logic [3:0] rot_mask(input logic [1:0] typ, input logic [1:0] rot);
      logic [3:0] m;
      case (typ)
         2'd0:    m = 4'b0001;
         2'd1:    m = 4'b0011;
         2'd2:    m = 4'b1101;
         default: m = 4'b1111;
      endcase
      for (int i = 0; i < 3; i++) begin
         if (i < int'(rot)) m = {m[1], m[3], m[0], m[2]};
      end
      return m;
   endfunction

   function automatic logic in_range(input int r, input int c);
      return (r >= 0) && (r <= ROWS-2) && (c >= 0) && (c <= COLS-2);
   endfunction

   function automatic logic [N-1:0] place(input logic [3:0] m, input int r, input int c);
      logic [N-1:0] p;
      p = '0;
      if (in_range(r, c)) begin
         p[r*COLS + c]         = m[0];
         p[r*COLS + c + 1]     = m[1];
         p[(r+1)*COLS + c]     = m[2];
         p[(r+1)*COLS + c + 1] = m[3];
      end
      return p;
   endfunction

   function automatic logic fits(input logic [3:0] m, input int r, input int c,
                                 input logic [N-1:0] b);
      return in_range(r, c) && ((place(m, r, c) & b) == '0);
   endfunction

   function automatic logic [LOC_W-1:0] loc_of(input int r, input int c);
      return LOC_W'(r*COLS + c);
   endfunction

   logic            drop_on;
   logic            drop_req;
   logic [3:0]      cur_mask;
   logic            down_ok;
   logic [1:0]      mv_rot;
   int              mv_col;
   logic            mv_ok;
   logic            spawn_ok;
   logic [COLS-1:0] scan_cells;
   logic [N-1:0]    shifted;
   logic            grav;
   logic            do_move;

`ifdef TETRIS_HARD_DROP_EN
   logic drop_q;
   assign drop_on  = drop_q;
   assign drop_req = hard_drop;

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         drop_q <= 1'b0;
      end else if (state_q == S_FALL && hard_drop) begin
         drop_q <= 1'b1;
      end else if (state_q == S_LOCK) begin
         drop_q <= 1'b0;
      end
   end
`else
   assign drop_on  = 1'b0;
   assign drop_req = 1'b0;
`endif

   always_comb begin
      cur_mask = rot_mask(piece_q, rot_q);
      down_ok  = fits(cur_mask, int'(row_q) + 1, int'(col_q), board_q);
      mv_rot   = rot_q;
      mv_col   = int'(col_q);
      case (move)
         2'b01:   mv_col = int'(col_q) - 1;
         2'b10:   mv_col = int'(col_q) + 1;
         2'b11:   mv_rot = rot_q + 2'd1;
         default: mv_col = int'(col_q);
      endcase
      mv_ok    = fits(rot_mask(piece_q, mv_rot), int'(row_q), mv_col, board_q);
      spawn_ok = fits(rot_mask(piece_in, 2'd0), 0, SPAWN_COL, board_q);
      // A latched tick wins over a fresh move; an active drop overrides both.
      grav     = drop_on || (!drop_req && (pend_q || (tick && move == 2'b00)));
      do_move  = !drop_on && !drop_req && !pend_q && (move != 2'b00);

      scan_cells = board_q[int'(scan_q)*COLS +: COLS];
      shifted    = board_q;
      shifted[COLS-1:0] = '0;
      for (int r = 1; r < ROWS; r++) begin
         if (r <= int'(scan_q)) shifted[r*COLS +: COLS] = board_q[(r-1)*COLS +: COLS];
      end
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         state_q   <= S_SPAWN;
         board_q   <= '0;
         piece_q   <= '0;
         rot_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
         loc_q     <= '0;
         touched_q <= 1'b0;
         lines_q   <= '0;
         go_q      <= 1'b0;
         scan_q    <= '0;
         pend_q    <= 1'b0;
      end else begin
         touched_q <= 1'b0;
         case (state_q)
            S_SPAWN: begin
               piece_q <= piece_in;
               rot_q   <= 2'd0;
               row_q   <= '0;
               col_q   <= COL_W'(SPAWN_COL);
               loc_q   <= loc_of(0, SPAWN_COL);
               pend_q  <= 1'b0;
               if (spawn_ok) begin
                  state_q <= S_FALL;
               end else begin
                  state_q <= S_OVER;
                  go_q    <= 1'b1;
               end
            end
            S_FALL: begin
               pend_q <= do_move && tick;
               if (grav) begin
                  if (down_ok) begin
                     row_q <= row_q + ROW_W'(1);
                     loc_q <= loc_of(int'(row_q) + 1, int'(col_q));
                  end else begin
                     state_q <= S_LOCK;
                  end
               end else if (do_move && mv_ok) begin
                  rot_q <= mv_rot;
                  col_q <= COL_W'(mv_col);
                  loc_q <= loc_of(int'(row_q), mv_col);
               end
            end
            S_LOCK: begin
               board_q   <= board_q | place(cur_mask, int'(row_q), int'(col_q));
               touched_q <= 1'b1;
               scan_q    <= ROW_W'(ROWS-1);
               pend_q    <= 1'b0;
               state_q   <= S_CLEAR;
            end
            S_CLEAR: begin
               if (&scan_cells) begin
                  board_q <= shifted;
                  if (lines_q != 16'hFFFF) lines_q <= lines_q + 16'd1;
               end else if (scan_q == '0) begin
                  state_q <= S_SPAWN;
               end else begin
                  scan_q <= scan_q - ROW_W'(1);
               end
            end
            default: state_q <= S_OVER;
         endcase
      end
   end

   assign board_out     = board_q;
   assign curr_piece    = piece_q;
   assign rotation      = rot_q;
   assign location      = loc_q;
   assign touched       = touched_q;
   assign lines_cleared = lines_q;
   assign game_over     = go_q;
   assign state         = state_q;

endmodule

// File: tb/tb_tetris_dp_param.sv
// Directed bench for tetris_dp_param at COLS=4, ROWS=8: vector table plus hand sequences.
module tb_tetris_dp_param;
   logic        clka;
   logic        restart_n;
   logic        tick;
   logic [1:0]  move;
   logic [1:0]  piece_in;
`ifdef TETRIS_HARD_DROP_EN
   logic        hard_drop;
`endif
   logic [31:0] board_out;
   logic [1:0]  curr_piece;
   logic [1:0]  rotation;
   logic [4:0]  location;
   logic        touched;
   logic [15:0] lines_cleared;
   logic        game_over;
   logic [2:0]  state;

   tetris_dp_param #(.COLS(4), .ROWS(8)) dut (
      .clka          (clka),
      .restart_n     (restart_n),
      .tick          (tick),
      .move          (move),
      .piece_in      (piece_in),
`ifdef TETRIS_HARD_DROP_EN
      .hard_drop     (hard_drop),
`endif
      .board_out     (board_out),
      .curr_piece    (curr_piece),
      .rotation      (rotation),
      .location      (location),
      .touched       (touched),
      .lines_cleared (lines_cleared),
      .game_over     (game_over),
      .state         (state)
   );

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   typedef struct packed {
      logic [2:0]  st;
      logic [1:0]  pc;
      logic [1:0]  rot;
      logic [4:0]  loc;
      logic [31:0] brd;
      logic        tch;
      logic [15:0] lines;
      logic        go;
   } out_t;

   typedef struct {
      logic       tk;
      logic [1:0] mv;
      logic [1:0] pc;
      out_t       exp;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic out_t mk(input logic [2:0] st, input logic [1:0] pc, input logic [1:0] rot,
                               input logic [4:0] loc, input logic [31:0] brd, input logic tch,
                               input logic [15:0] lines, input logic go);
      out_t o;
      o.st = st; o.pc = pc; o.rot = rot; o.loc = loc;
      o.brd = brd; o.tch = tch; o.lines = lines; o.go = go;
      return o;
   endfunction

   task automatic check_out(input string name, input out_t exp);
      out_t act;
      act = mk(state, curr_piece, rotation, location, board_out, touched, lines_cleared, game_over);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got st=%0d pc=%0d rot=%0d loc=%0d brd=%h tch=%b lines=%0d go=%b, want st=%0d pc=%0d rot=%0d loc=%0d brd=%h tch=%b lines=%0d go=%b",
                    name, act.st, act.pc, act.rot, act.loc, act.brd, act.tch, act.lines, act.go,
                    exp.st, exp.pc, exp.rot, exp.loc, exp.brd, exp.tch, exp.lines, exp.go);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   task automatic step(input logic t, input logic [1:0] m, input logic [1:0] p);
      tick = t; move = m; piece_in = p;
      @(posedge clka);
      #1;
      tick = 1'b0; move = 2'b00;
   endtask

   task automatic do_reset(input logic [1:0] p);
      tick = 1'b0; move = 2'b00; piece_in = p;
      restart_n = 1'b0;
      #2;
      check_out("reset", mk(3'd0, 2'd0, 2'd0, 5'd0, 32'h0, 1'b0, 16'd0, 1'b0));
      @(negedge clka);
      restart_n = 1'b1;
   endtask

   task automatic tick_to_lock(input string name, input logic [1:0] p);
      int n;
      n = 0;
      while (state != 3'd2 && n < 30) begin
         step(1'b1, 2'b00, p);
         n++;
      end
      check_int(name, int'(state), 2);
   endtask

   task automatic wait_spawn(input string name, input logic [1:0] p);
      int n;
      n = 0;
      while (state != 3'd0 && n < 40) begin
         step(1'b0, 2'b00, p);
         n++;
      end
      check_int(name, int'(state), 0);
   endtask

   vec_t tbl[23];

   initial begin
      int cnt;
      // Spawn, illegal left moves, gravity down to a lock, then a clean CLEAR pass.
      tbl[0]  = '{1'b0, 2'b00, 2'd3, mk(3'd1, 2'd3, 2'd0, 5'd1,  32'h0, 1'b0, 16'd0, 1'b0)};
      tbl[1]  = '{1'b0, 2'b01, 2'd3, mk(3'd1, 2'd3, 2'd0, 5'd0,  32'h0, 1'b0, 16'd0, 1'b0)};
      tbl[2]  = '{1'b0, 2'b01, 2'd3, mk(3'd1, 2'd3, 2'd0, 5'd0,  32'h0, 1'b0, 16'd0, 1'b0)};
      tbl[3]  = '{1'b0, 2'b01, 2'd3, mk(3'd1, 2'd3, 2'd0, 5'd0,  32'h0, 1'b0, 16'd0, 1'b0)};
      tbl[4]  = '{1'b0, 2'b10, 2'd3, mk(3'd1, 2'd3, 2'd0, 5'd1,  32'h0, 1'b0, 16'd0, 1'b0)};
      for (int i = 0; i < 6; i++)
         tbl[5+i] = '{1'b1, 2'b00, 2'd3,
                      mk(3'd1, 2'd3, 2'd0, 5'(1 + 4*(i+1)), 32'h0, 1'b0, 16'd0, 1'b0)};
      tbl[11] = '{1'b1, 2'b00, 2'd3, mk(3'd2, 2'd3, 2'd0, 5'd25, 32'h0, 1'b0, 16'd0, 1'b0)};
      tbl[12] = '{1'b0, 2'b00, 2'd3, mk(3'd3, 2'd3, 2'd0, 5'd25, 32'h66000000, 1'b1, 16'd0, 1'b0)};
      for (int i = 0; i < 7; i++)
         tbl[13+i] = '{1'b1, 2'b10, 2'd0,
                       mk(3'd3, 2'd3, 2'd0, 5'd25, 32'h66000000, 1'b0, 16'd0, 1'b0)};
      tbl[20] = '{1'b0, 2'b00, 2'd0, mk(3'd0, 2'd3, 2'd0, 5'd25, 32'h66000000, 1'b0, 16'd0, 1'b0)};
      tbl[21] = '{1'b0, 2'b00, 2'd0, mk(3'd1, 2'd0, 2'd0, 5'd1,  32'h66000000, 1'b0, 16'd0, 1'b0)};
      tbl[22] = '{1'b0, 2'b00, 2'd0, mk(3'd1, 2'd0, 2'd0, 5'd1,  32'h66000000, 1'b0, 16'd0, 1'b0)};

      tick = 1'b0; move = 2'b00; piece_in = 2'd3;
`ifdef TETRIS_HARD_DROP_EN
      hard_drop = 1'b0;
`endif
      restart_n = 1'b1;
      #1;
      do_reset(2'd3);
      for (int i = 0; i < 23; i++) begin
         step(tbl[i].tk, tbl[i].mv, tbl[i].pc);
         check_out($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Two bottom-row locks clear both rows.
      do_reset(2'd3);
      step(1'b0, 2'b00, 2'd3);
      check_out("clr_spawn1", mk(3'd1, 2'd3, 2'd0, 5'd1, 32'h0, 1'b0, 16'd0, 1'b0));
      step(1'b0, 2'b01, 2'd3);
      check_out("clr_left", mk(3'd1, 2'd3, 2'd0, 5'd0, 32'h0, 1'b0, 16'd0, 1'b0));
      tick_to_lock("clr_lock1", 2'd3);
      step(1'b0, 2'b00, 2'd3);
      check_out("clr_board1", mk(3'd3, 2'd3, 2'd0, 5'd24, 32'h33000000, 1'b1, 16'd0, 1'b0));
      wait_spawn("clr_spawnwait", 2'd3);
      step(1'b0, 2'b00, 2'd3);
      step(1'b0, 2'b10, 2'd3);
      check_out("clr_right", mk(3'd1, 2'd3, 2'd0, 5'd2, 32'h33000000, 1'b0, 16'd0, 1'b0));
      tick_to_lock("clr_lock2", 2'd3);
      step(1'b0, 2'b00, 2'd3);
      check_out("clr_board2", mk(3'd3, 2'd3, 2'd0, 5'd26, 32'hFF000000, 1'b1, 16'd0, 1'b0));
      cnt = 0;
      while (state == 3'd3 && cnt < 50) begin
         cnt++;
         step(1'b0, 2'b00, 2'd3);
      end
      check_int("clr_cycles", cnt, 10);
      check_out("clr_done", mk(3'd0, 2'd3, 2'd0, 5'd26, 32'h0, 1'b0, 16'd2, 1'b0));

      // Stack four pieces in the centre; the fifth spawn tops out.
      do_reset(2'd3);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 2'b00, 2'd3);
         tick_to_lock($sformatf("stack_lock%0d", k), 2'd3);
         wait_spawn($sformatf("stack_spawn%0d", k), 2'd3);
      end
      step(1'b0, 2'b00, 2'd3);
      check_out("over", mk(3'd4, 2'd3, 2'd0, 5'd1, 32'h66666666, 1'b0, 16'd0, 1'b1));
      step(1'b1, 2'b01, 2'd1);
      check_out("over_hold", mk(3'd4, 2'd3, 2'd0, 5'd1, 32'h66666666, 1'b0, 16'd0, 1'b1));
      do_reset(2'd2);

      // Move and tick together: move now, row one cycle later; extra tick while pending is dropped.
      step(1'b0, 2'b00, 2'd2);
      check_out("rot_spawn", mk(3'd1, 2'd2, 2'd0, 5'd1, 32'h0, 1'b0, 16'd0, 1'b0));
      step(1'b1, 2'b11, 2'd2);
      check_out("rot_move", mk(3'd1, 2'd2, 2'd1, 5'd1, 32'h0, 1'b0, 16'd0, 1'b0));
      step(1'b0, 2'b00, 2'd2);
      check_out("rot_pend", mk(3'd1, 2'd2, 2'd1, 5'd5, 32'h0, 1'b0, 16'd0, 1'b0));
      step(1'b0, 2'b00, 2'd2);
      check_out("rot_idle", mk(3'd1, 2'd2, 2'd1, 5'd5, 32'h0, 1'b0, 16'd0, 1'b0));
      step(1'b1, 2'b01, 2'd2);
      check_out("pend_move", mk(3'd1, 2'd2, 2'd1, 5'd4, 32'h0, 1'b0, 16'd0, 1'b0));
      step(1'b1, 2'b00, 2'd2);
      check_out("pend_drop", mk(3'd1, 2'd2, 2'd1, 5'd8, 32'h0, 1'b0, 16'd0, 1'b0));
      step(1'b0, 2'b00, 2'd2);
      check_out("pend_idle", mk(3'd1, 2'd2, 2'd1, 5'd8, 32'h0, 1'b0, 16'd0, 1'b0));
      tick_to_lock("rot_lock", 2'd2);
      step(1'b0, 2'b00, 2'd2);
      check_out("rot_board", mk(3'd3, 2'd2, 2'd1, 5'd24, 32'h13000000, 1'b1, 16'd0, 1'b0));
      step(1'b0, 2'b00, 2'd2);
      do_reset(2'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/tetris_dp_param.md
# tetris_dp_param

Parametrised successor to the Tetris datapath. It holds a COLS×ROWS playfield register, the active piece (type, rotation, location), and a control FSM, all on a single clock. The FSM spawns pieces, applies player moves and gravity ticks, locks pieces, and clears full rows. It sits between the input/randomiser logic and the display scanner, and replaces the fixed 4×8, two-phase-clock datapath.

## Interface
- COLS, 4: playfield columns, ≥2
- ROWS, 8: playfield rows, ≥2
- LOC_W, $clog2(COLS*ROWS): location index width
- clka  in  1  clock, rising edge
- restart_n  in  1  asynchronous, active-low reset
- tick  in  1  gravity step request, one-cycle pulse
- move  in  2  00 none, 01 left, 10 right, 11 rotate clockwise
- piece_in  in  2  next piece type from the randomiser
- hard_drop  in  1  hard-drop request (only with TETRIS_HARD_DROP_EN)
- board_out  out  COLS*ROWS  locked cells; bit = row*COLS+col, row 0 at top
- curr_piece  out  2  active piece type
- rotation  out  2  active rotation, 0–3
- location  out  LOC_W  anchor (top-left of the 2×2 box) as row*COLS+col
- touched  out  1  one-cycle pulse on lock
- lines_cleared  out  16  saturating cleared-row count
- game_over  out  1  high in OVER
- state  out  3  SPAWN=0, FALL=1, LOCK=2, CLEAR=3, OVER=4

## Operation
- Pieces occupy a 2×2 box with cells b0 (top-left), b1 (top-right), b2 (bottom-left), b3 (bottom-right).
- Rotation-0 masks:
  - type 0: {b0}
  - type 1: {b0,b1}
  - type 2: {b0,b2,b3}
  - type 3: all four cells
- Each clockwise rotation maps b0→b1→b3→b2→b0.
- A placement is legal when anchor col ≤ COLS-2, anchor row ≤ ROWS-2, and the mask does not overlap board_out.
- SPAWN:
  - Samples piece_in, sets rotation 0, col (COLS-2)/2, row 0.
  - Legal placement → FALL; otherwise → OVER.
- FALL:
  - A non-zero move is applied only if the resulting placement is legal; an illegal move is silently ignored.
  - On tick: row+1 if legal, else → LOCK.
- LOCK: ORs the mask into board_out, pulses touched, sets the scan row to ROWS-1, → CLEAR.
- CLEAR, one row per cycle, scanning upward from the bottom:
  - Full row: every row above shifts down one, row 0 is zeroed, lines_cleared increments (saturates at 0xFFFF), and the same row is rescanned.
  - Not full: the scan row decrements.
  - After row 0 is checked → SPAWN.
- OVER: holds; ignores all inputs until reset.
- Reset: board_out=0, curr_piece=0, rotation=0, location=0, touched=0, lines_cleared=0, game_over=0, state=SPAWN.

## Timing
- All state changes occur on the rising clka edge; all outputs are registered.
- SPAWN takes 1 cycle; LOCK takes 1 cycle; CLEAR takes ROWS + (rows cleared) cycles.
- tick and a non-zero move in the same FALL cycle: the move is applied and the tick is latched in a pending flag. The pending tick is applied the next cycle; a second tick arriving while one is pending is dropped.
- tick and move outside FALL are ignored, and no pending flag is set.
- Reset asserted mid-CLEAR or mid-LOCK aborts immediately to reset values.

## Configuration
- TETRIS_HARD_DROP_EN defined:
  - The hard_drop port exists.
  - Asserting it in FALL sets a drop flag. While the flag is set, the piece moves down one row per cycle and ignores move and tick.
  - When the next row is blocked → LOCK. The flag clears in LOCK.
- TETRIS_HARD_DROP_EN undefined: the hard_drop port and its logic are absent; behaviour is otherwise identical.

## Test plan
All scenarios use COLS=4, ROWS=8.
- Release reset with piece_in=3 → next cycle state=1, location=1, rotation=0, board_out=0.
- In FALL with piece 3, move=01 three times → location=0 after the first move, unchanged after the second and third (illegal moves ignored).
- Piece 3 at col 1, 7 ticks → row 6 after 6 ticks. The 7th tick → state=2, touched high for exactly 1 cycle, board_out=0x66000000, then CLEAR for 8 cycles, then SPAWN.
- Lock piece 3 at col 0 and at col 2 on the bottom rows (board 0xFF000000) → CLEAR runs 10 cycles, board_out=0, lines_cleared=2.
- Stack four type-3 pieces at col 1; the fifth spawn collides → state=4, game_over=1. A following move=01 and tick leave all outputs unchanged; reset returns everything to reset values.
- Piece 2: move=11 and tick in the same cycle → rotation=1 and mask {b0,b1,b2} that cycle; row increments on the following cycle.
